// File: rtl/dds_pkg.sv
// Shared DDS definitions: default phase width, FTW-recovery FSM states, nibble-count helper.
package dds_pkg;

  localparam int DDS_PHASE_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    ACC  = 2'd2,
    OUT  = 2'd3
  } ftw_state_t;

  function automatic int ftw_nibbles(input int phase_w);
    return phase_w / 4;
  endfunction

endpackage

// File: rtl/dds_ftw_recover_sub4.sv
// 4-bit subtractor slice with borrow in/out; purely combinational, no backpressure.
module sub4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       borrow_in,
  output logic [3:0] diff,
  output logic       borrow_out
);

  // Bit 4 of the 5-bit difference is set exactly when a - b - borrow_in goes negative.
  always_comb begin
    {borrow_out, diff} = {1'b0, a} - {1'b0, b} - {4'b0000, borrow_in};
  end

endmodule

// File: rtl/dds_ftw_recover.sv
// Recovers the DDS tuning word by nibble-serially differencing phase samples and averaging 2^AVG_LOG2 of them.
// One sample per PHASE_W/4+2 cycles; ftw_valid holds until ftw_ready and stalls phase input meanwhile.
module dds_ftw_recover
  import dds_pkg::*;
#(
  parameter int PHASE_W  = DDS_PHASE_W,
  parameter int AVG_LOG2 = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic               phase_valid,
  output logic               phase_ready,
  output logic [PHASE_W-1:0] ftw_out,
  output logic               ftw_valid,
  input  logic               ftw_ready
);

  localparam int NIB   = ftw_nibbles(PHASE_W);
  localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int SUM_W = PHASE_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NIB - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << AVG_LOG2);

  ftw_state_t         state_q,  state_d;
  logic [NIB_W-1:0]   nib_q,    nib_d;
  logic               borrow_q, borrow_d;
  logic               primed_q, primed_d;
  logic [PHASE_W-1:0] prev_q,   prev_d;
  logic [PHASE_W-1:0] cur_q,    cur_d;
  logic [PHASE_W-1:0] diff_q,   diff_d;
  logic [SUM_W-1:0]   sum_q,    sum_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [PHASE_W-1:0] ftw_q,    ftw_d;

  logic [3:0] nib_diff;
  logic       nib_borrow;

  sub4 u_sub4 (
    .a          (cur_q[{nib_q, 2'b00} +: 4]),
    .b          (prev_q[{nib_q, 2'b00} +: 4]),
    .borrow_in  (borrow_q),
    .diff       (nib_diff),
    .borrow_out (nib_borrow)
  );

  assign phase_ready = (state_q == IDLE);
  assign ftw_valid   = (state_q == OUT);
  assign ftw_out     = ftw_q;

  always_comb begin
    state_d  = state_q;
    nib_d    = nib_q;
    borrow_d = borrow_q;
    primed_d = primed_q;
    prev_d   = prev_q;
    cur_d    = cur_q;
    diff_d   = diff_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    ftw_d    = ftw_q;
    unique case (state_q)
      IDLE: begin
        if (phase_valid) begin
          cur_d = phase_in;
          if (!primed_q) begin
            prev_d   = phase_in;
            primed_d = 1'b1;
          end else begin
            state_d  = SUB;
            nib_d    = '0;
            borrow_d = 1'b0;
          end
        end
      end
      SUB: begin
        diff_d[{nib_q, 2'b00} +: 4] = nib_diff;
        borrow_d = nib_borrow;
        nib_d    = nib_q + NIB_W'(1);
        // The last borrow is dropped so the difference wraps modulo 2^PHASE_W.
        if (nib_q == NIB_LAST) begin
          prev_d  = cur_q;
          state_d = ACC;
        end
      end
      ACC: begin
        sum_d = sum_q + SUM_W'(diff_q);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_FULL) begin
          ftw_d   = PHASE_W'(sum_d >> AVG_LOG2);
          state_d = OUT;
        end else begin
          state_d = IDLE;
        end
      end
      OUT: begin
        // prev is kept so the next sample yields a real difference.
        if (ftw_ready) begin
          sum_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      nib_q    <= '0;
      borrow_q <= 1'b0;
      primed_q <= 1'b0;
      prev_q   <= '0;
      cur_q    <= '0;
      diff_q   <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      ftw_q    <= '0;
    end else begin
      state_q  <= state_d;
      nib_q    <= nib_d;
      borrow_q <= borrow_d;
      primed_q <= primed_d;
      prev_q   <= prev_d;
      cur_q    <= cur_d;
      diff_q   <= diff_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      ftw_q    <= ftw_d;
    end
  end

endmodule
